// File: rtl/change_dispenser_if.sv
// Bundle of the payout request and coin-output signals between the
// calculation side (master) and the change dispenser (slave).
interface change_dispenser_if;
  logic       start;
  logic [6:0] change;
  logic       busy;
  logic       done;
  logic       out_coin10;
  logic       out_coin5;
  logic       out_coin2;
  logic       out_coin1;
  logic [6:0] remaining;
  logic [3:0] coins_out;

  modport master (
    output start, change,
    input  busy, done, out_coin10, out_coin5, out_coin2, out_coin1,
           remaining, coins_out
  );

  modport slave (
    input  start, change,
    output busy, done, out_coin10, out_coin5, out_coin2, out_coin1,
           remaining, coins_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a latched change amount as a greedy sequence of 10/5/2/1 coin
// pulses, one coin at a time, and pulses done when the payout is complete.
module change_dispenser #(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam int unsigned MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  // Counter only ever holds MAX_CYC-1 down to 0.
  localparam int          CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  // Coin one-hot encoding, bit order {10, 5, 2, 1}.
  localparam logic [3:0] COIN_10 = 4'b1000;
  localparam logic [3:0] COIN_5  = 4'b0100;
  localparam logic [3:0] COIN_2  = 4'b0010;
  localparam logic [3:0] COIN_1  = 4'b0001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       remaining_q, remaining_d;
  logic [3:0]       coins_q, coins_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [3:0] pick_denom(input logic [6:0] amount);
    if (amount >= 7'd10)     return COIN_10;
    else if (amount >= 7'd5) return COIN_5;
    else if (amount >= 7'd2) return COIN_2;
    else                     return COIN_1;
  endfunction

  function automatic logic [6:0] denom_value(input logic [3:0] sel);
    case (sel)
      COIN_10: return 7'd10;
      COIN_5:  return 7'd5;
      COIN_2:  return 7'd2;
      default: return 7'd1;
    endcase
  endfunction

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    coins_d     = coins_q;
    sel_d       = sel_q;
    coin_d      = coin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.change;
          coins_d     = 4'd0;
          if (bus.change == 7'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_SELECT;
            busy_d  = 1'b1;
          end
        end
      end

      S_SELECT: begin
        sel_d   = pick_denom(remaining_q);
        coin_d  = sel_d;
        cnt_d   = PULSE_LOAD;
        state_d = S_PULSE;
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          coin_d      = 4'd0;
          // The chosen denom never exceeds remaining, so this cannot wrap.
          remaining_d = remaining_q - denom_value(sel_q);
          coins_d     = (coins_q == 4'd15) ? coins_q : coins_q + 4'd1;
          cnt_d       = GAP_LOAD;
          state_d     = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          if (remaining_q == 7'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_SELECT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        coin_d  = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset is synchronous and active-high even though the port keeps the
  // legacy rst_n name; asserting it mid-payout throws the unpaid amount away.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= 7'd0;
      coins_q     <= 4'd0;
      sel_q       <= 4'd0;
      coin_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      coins_q     <= coins_d;
      sel_q       <= sel_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.out_coin10 = coin_q[3];
  assign bus.out_coin5  = coin_q[2];
  assign bus.out_coin2  = coin_q[1];
  assign bus.out_coin1  = coin_q[0];
  assign bus.remaining  = remaining_q;
  assign bus.coins_out  = coins_q;

endmodule
